// File: rtl/lcd_cfg_pkg.sv
// lcd_cfg_pkg
//   Shared definitions for the LCD driver configuration slave: register
//   offsets, CTRL/STATUS/IRQ_EN bit positions and the AHB response state.
package lcd_cfg_pkg;

    // Register offsets (byte addresses within the slave window)
    localparam logic [31:0] LCD_CTRL_OFFSET       = 32'h0000_0000;
    localparam logic [31:0] LCD_INSTR_OFFSET      = 32'h0000_0004;
    localparam logic [31:0] LCD_RDATA_OFFSET      = 32'h0000_0008;
    localparam logic [31:0] LCD_PRESCALER_OFFSET  = 32'h0000_000C;
    localparam logic [31:0] LCD_STATUS_OFFSET     = 32'h0000_0010;
    localparam logic [31:0] LCD_IRQ_EN_OFFSET     = 32'h0000_0014;
    localparam logic [31:0] LCD_DRIVER_MAX_OFFSET = 32'h0000_0014;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_PHY_READ_BIT = 1;
    localparam int CTRL_FLUSH_BIT    = 2;

    // STATUS field positions
    localparam int STATUS_INSTR_LEVEL_LSB = 0;
    localparam int STATUS_RDATA_LEVEL_LSB = 8;
    localparam int STATUS_INSTR_FULL_BIT  = 16;
    localparam int STATUS_INSTR_EMPTY_BIT = 17;
    localparam int STATUS_RDATA_EMPTY_BIT = 18;
    localparam int STATUS_INSTR_OVF_BIT   = 24;
    localparam int STATUS_RDATA_OVF_BIT   = 25;
    localparam int STATUS_RDATA_UDF_BIT   = 26;

    // IRQ_EN bit positions
    localparam int IRQ_INSTR_EMPTY_BIT = 0;
    localparam int IRQ_RDATA_AVAIL_BIT = 1;
    localparam int IRQ_ERROR_BIT       = 2;

    // AHB response sequencing: OKAY, first error cycle (wait), second error cycle
    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } resp_state_e;

endpackage

// File: rtl/lcd_cfg_sync_fifo.sv
// lcd_cfg_sync_fifo
//   Synchronous first-word fall-through FIFO.
//   Ports:
//     clk_i, rst_i : clock, asynchronous active-high reset
//     push, din    : write strobe and data; accepted when not full, or when
//                    full with a same-cycle effective pop
//     pop          : read strobe; ignored when empty
//     flush        : clears the FIFO, overriding push and pop
//     dout         : current head (undefined content when empty)
//     full, empty, level : occupancy
module lcd_cfg_sync_fifo
    import lcd_cfg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             pop_eff_s;
    logic             push_eff_s;

    assign full       = (level_r == LVL_W'(DEPTH));
    assign empty      = (level_r == {LVL_W{1'b0}});
    assign level      = level_r;
    assign dout       = mem_r[rd_ptr_r];
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push
    assign pop_eff_s  = pop & ~empty;
    assign push_eff_s = push & (~full | pop_eff_s);

    // Pointer and level bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_eff_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_eff_s, pop_eff_s})
                2'b10:   level_r <= level_r + LVL_W'(1'b1);
                2'b01:   level_r <= level_r - LVL_W'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; content is irrelevant while empty, so it carries no reset
    always_ff @(posedge clk_i) begin
        if (push_eff_s & ~flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/lcd_driver_cfg_fifo.sv
// lcd_driver_cfg_fifo
//   AHB-lite register slave configuring the HD44780 PHY: instruction FIFO
//   toward the PHY, read-data FIFO from the PHY, sticky error flags and a
//   maskable registered interrupt.
//   Ports:
//     clk_i, rst_i            : clock, asynchronous active-high reset
//     hsel_i .. htrans_i      : AHB-lite address/control and write data
//     hrdata_o, hready_out_o, hresp_o : AHB-lite data-phase response
//     phy_read_i              : PHY consumed the instruction FIFO head
//     rdata_valid_i, lcd_rdata_i : PHY read result pushed into the read FIFO
//     prescaler_10ns_o, phy_enable_o : PHY configuration
//     lcd_instr_o, valid_instr_o     : instruction FIFO head / not-empty
//     irq_o                   : registered interrupt
module lcd_driver_cfg_fifo
    import lcd_cfg_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int INSTR_WIDTH      = 10,
    parameter int PRESCALER_WIDTH  = 16,
    parameter int ADDR_WIDTH       = 12,
    parameter int INSTR_FIFO_DEPTH = 8,
    parameter int RDATA_FIFO_DEPTH = 4,
    parameter int PRESCALER_RESET  = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       hsel_i,
    input  logic [ADDR_WIDTH-1:0]      haddr_i,
    input  logic [31:0]                hwdata_i,
    input  logic                       hwrite_i,
    input  logic [1:0]                 htrans_i,
    output logic [31:0]                hrdata_o,
    output logic                       hready_out_o,
    output logic                       hresp_o,
    input  logic                       phy_read_i,
    input  logic                       rdata_valid_i,
    input  logic [DATA_WIDTH-1:0]      lcd_rdata_i,
    output logic [PRESCALER_WIDTH-1:0] prescaler_10ns_o,
    output logic                       phy_enable_o,
    output logic [INSTR_WIDTH-1:0]     lcd_instr_o,
    output logic                       valid_instr_o,
    output logic                       irq_o
);

    localparam int ILVL_W = $clog2(INSTR_FIFO_DEPTH+1);
    localparam int RLVL_W = $clog2(RDATA_FIFO_DEPTH+1);

    // Captured address phase
    logic                  dp_valid_r;
    logic                  dp_write_r;
    logic                  dp_err_r;
    logic [ADDR_WIDTH-1:0] dp_addr_r;
    logic [31:0]           dp_addr_ext_s;
    logic                  addr_accept_s;

    // Response sequencing
    resp_state_e state_r;
    resp_state_e state_next_s;
    resp_state_e resp_cur_s;

    // Data-phase decode
    logic dp_live_s;
    logic wr_s;
    logic rd_s;
    logic instr_ovf_err_s;
    logic err_now_s;
    logic ok_wr_s;
    logic ok_rd_s;
    logic flush_s;

    // FIFO interfaces
    logic                   instr_push_s;
    logic                   instr_pop_s;
    logic [INSTR_WIDTH-1:0] instr_dout_s;
    logic                   instr_full_s;
    logic                   instr_empty_s;
    logic [ILVL_W-1:0]      instr_level_s;
    logic                   rdata_push_s;
    logic                   rdata_pop_s;
    logic [DATA_WIDTH-1:0]  rdata_dout_s;
    logic                   rdata_full_s;
    logic                   rdata_empty_s;
    logic [RLVL_W-1:0]      rdata_level_s;

    // Configuration and status state
    logic                       enable_r;
    logic [PRESCALER_WIDTH-1:0] prescaler_r;
    logic [2:0]                 irq_en_r;
    logic                       instr_ovf_r;
    logic                       rdata_ovf_r;
    logic                       rdata_udf_r;
    logic                       irq_r;
    logic                       irq_next_s;
    logic                       instr_ovf_set_s;
    logic                       rdata_ovf_set_s;
    logic                       rdata_udf_set_s;
    logic                       status_w1c_s;
    logic [31:0]                status_s;
    logic                       unused_bits_s;

    assign addr_accept_s = hsel_i & htrans_i[1] & hready_out_o;
    assign dp_addr_ext_s = 32'(dp_addr_r);

    // Address-phase capture; held while the bus is stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_err_r   <= 1'b0;
            dp_addr_r  <= {ADDR_WIDTH{1'b0}};
        end else if (hready_out_o) begin
            dp_valid_r <= addr_accept_s;
            dp_write_r <= hwrite_i;
            dp_err_r   <= addr_accept_s & (32'(haddr_i) > LCD_DRIVER_MAX_OFFSET);
            dp_addr_r  <= haddr_i;
        end else begin
            dp_valid_r <= dp_valid_r;
            dp_write_r <= dp_write_r;
            dp_err_r   <= dp_err_r;
            dp_addr_r  <= dp_addr_r;
        end
    end

    // In the second error cycle the captured transfer is already answered
    assign dp_live_s       = dp_valid_r & (state_r == OKAY);
    assign wr_s            = dp_live_s & dp_write_r;
    assign rd_s            = dp_live_s & ~dp_write_r;
    // Full is judged on the registered flag, so a same-cycle PHY pop does not rescue the write
    assign instr_ovf_err_s = wr_s & (dp_addr_ext_s == LCD_INSTR_OFFSET) & instr_full_s;
    assign err_now_s       = dp_live_s & (dp_err_r | instr_ovf_err_s);
    assign ok_wr_s         = wr_s & ~err_now_s;
    assign ok_rd_s         = rd_s & ~err_now_s;

    // Response state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= OKAY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Current response and next state: ERR1 is the stalled data-phase cycle itself
    always_comb begin
        resp_cur_s   = OKAY;
        state_next_s = OKAY;
        case (state_r)
            ERR2:    resp_cur_s = ERR2;
            OKAY:    resp_cur_s = err_now_s ? ERR1 : OKAY;
            default: resp_cur_s = OKAY;
        endcase
        case (resp_cur_s)
            ERR1:    state_next_s = ERR2;
            default: state_next_s = OKAY;
        endcase
    end

    // Bus handshake outputs from the current response state
    always_comb begin
        hready_out_o = 1'b1;
        hresp_o      = 1'b0;
        case (resp_cur_s)
            ERR1: begin
                hready_out_o = 1'b0;
                hresp_o      = 1'b1;
            end
            ERR2: begin
                hready_out_o = 1'b1;
                hresp_o      = 1'b1;
            end
            default: begin
                hready_out_o = 1'b1;
                hresp_o      = 1'b0;
            end
        endcase
    end

    assign flush_s         = ok_wr_s & (dp_addr_ext_s == LCD_CTRL_OFFSET) & hwdata_i[CTRL_FLUSH_BIT];
    assign instr_push_s    = ok_wr_s & (dp_addr_ext_s == LCD_INSTR_OFFSET);
    assign instr_pop_s     = phy_read_i & ~flush_s;
    assign rdata_pop_s     = ok_rd_s & (dp_addr_ext_s == LCD_RDATA_OFFSET) & ~rdata_empty_s;
    assign rdata_push_s    = rdata_valid_i & ~flush_s;
    assign status_w1c_s    = ok_wr_s & (dp_addr_ext_s == LCD_STATUS_OFFSET);
    assign instr_ovf_set_s = instr_ovf_err_s;
    assign rdata_ovf_set_s = rdata_valid_i & rdata_full_s & ~rdata_pop_s & ~flush_s;
    assign rdata_udf_set_s = ok_rd_s & (dp_addr_ext_s == LCD_RDATA_OFFSET) & rdata_empty_s;

    lcd_cfg_sync_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (INSTR_FIFO_DEPTH)
    ) u_instr_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (instr_push_s),
        .pop   (instr_pop_s),
        .flush (flush_s),
        .din   (hwdata_i[INSTR_WIDTH-1:0]),
        .dout  (instr_dout_s),
        .full  (instr_full_s),
        .empty (instr_empty_s),
        .level (instr_level_s)
    );

    lcd_cfg_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RDATA_FIFO_DEPTH)
    ) u_rdata_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rdata_push_s),
        .pop   (rdata_pop_s),
        .flush (flush_s),
        .din   (lcd_rdata_i),
        .dout  (rdata_dout_s),
        .full  (rdata_full_s),
        .empty (rdata_empty_s),
        .level (rdata_level_s)
    );

    // Configuration registers written by OKAY data phases
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_r    <= 1'b0;
            prescaler_r <= PRESCALER_WIDTH'(PRESCALER_RESET);
            irq_en_r    <= 3'b000;
        end else begin
            if (ok_wr_s & (dp_addr_ext_s == LCD_CTRL_OFFSET)) begin
                enable_r <= hwdata_i[CTRL_ENABLE_BIT];
            end else begin
                enable_r <= enable_r;
            end
            if (ok_wr_s & (dp_addr_ext_s == LCD_PRESCALER_OFFSET)) begin
                prescaler_r <= hwdata_i[PRESCALER_WIDTH-1:0];
            end else begin
                prescaler_r <= prescaler_r;
            end
            if (ok_wr_s & (dp_addr_ext_s == LCD_IRQ_EN_OFFSET)) begin
                irq_en_r <= hwdata_i[2:0];
            end else begin
                irq_en_r <= irq_en_r;
            end
        end
    end

    // Sticky error flags; a new event in the same cycle as a W1C clear wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_ovf_r <= 1'b0;
            rdata_ovf_r <= 1'b0;
            rdata_udf_r <= 1'b0;
        end else begin
            instr_ovf_r <= instr_ovf_set_s |
                           (instr_ovf_r & ~(status_w1c_s & hwdata_i[STATUS_INSTR_OVF_BIT]));
            rdata_ovf_r <= rdata_ovf_set_s |
                           (rdata_ovf_r & ~(status_w1c_s & hwdata_i[STATUS_RDATA_OVF_BIT]));
            rdata_udf_r <= rdata_udf_set_s |
                           (rdata_udf_r & ~(status_w1c_s & hwdata_i[STATUS_RDATA_UDF_BIT]));
        end
    end

    assign irq_next_s = (irq_en_r[IRQ_INSTR_EMPTY_BIT] & instr_empty_s) |
                        (irq_en_r[IRQ_RDATA_AVAIL_BIT] & ~rdata_empty_s) |
                        (irq_en_r[IRQ_ERROR_BIT] & (instr_ovf_r | rdata_ovf_r | rdata_udf_r));

    // Interrupt output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_next_s;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_s                                       = 32'h0000_0000;
        status_s[STATUS_INSTR_LEVEL_LSB +: 8]          = 8'(instr_level_s);
        status_s[STATUS_RDATA_LEVEL_LSB +: 8]          = 8'(rdata_level_s);
        status_s[STATUS_INSTR_FULL_BIT]                = instr_full_s;
        status_s[STATUS_INSTR_EMPTY_BIT]               = instr_empty_s;
        status_s[STATUS_RDATA_EMPTY_BIT]               = rdata_empty_s;
        status_s[STATUS_INSTR_OVF_BIT]                 = instr_ovf_r;
        status_s[STATUS_RDATA_OVF_BIT]                 = rdata_ovf_r;
        status_s[STATUS_RDATA_UDF_BIT]                 = rdata_udf_r;
    end

    // Read-data mux; driven only during an OKAY read data phase
    always_comb begin
        hrdata_o = 32'h0000_0000;
        if (ok_rd_s) begin
            case (dp_addr_ext_s)
                LCD_CTRL_OFFSET: begin
                    hrdata_o[CTRL_ENABLE_BIT]   = enable_r;
                    hrdata_o[CTRL_PHY_READ_BIT] = phy_read_i;
                end
                LCD_INSTR_OFFSET:     hrdata_o = instr_empty_s ? 32'h0000_0000 : 32'(instr_dout_s);
                LCD_RDATA_OFFSET:     hrdata_o = rdata_empty_s ? 32'h0000_0000 : 32'(rdata_dout_s);
                LCD_PRESCALER_OFFSET: hrdata_o = 32'(prescaler_r);
                LCD_STATUS_OFFSET:    hrdata_o = status_s;
                LCD_IRQ_EN_OFFSET:    hrdata_o = 32'(irq_en_r);
                default:              hrdata_o = 32'h0000_0000;
            endcase
        end else begin
            hrdata_o = 32'h0000_0000;
        end
    end

    assign prescaler_10ns_o = prescaler_r;
    assign phy_enable_o     = enable_r;
    assign valid_instr_o    = ~instr_empty_s;
    assign lcd_instr_o      = instr_empty_s ? {INSTR_WIDTH{1'b0}} : instr_dout_s;
    assign irq_o            = irq_r;

    // Bits of the bus that carry no meaning for this slave
    assign unused_bits_s = &{1'b0, htrans_i[0], hwdata_i};

endmodule
